// File: rtl/com_responder.sv
// Target-side command responder: fetches ROM words, shifts them MSB-first over sclk/sdo/cs_n,
// then answers with NewCom or ComEnd. Define COM_RESPONDER_OVR_EN to add the sticky ovr flag.
module com_responder #(
    parameter int CMD_W   = 16,
    parameter int NUM_CMD = 8,
    parameter int ADDR_W  = 3,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Write,
    input  logic [CMD_W-1:0]  cmd_data,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic              NewCom,
    output logic              ComEnd,
    output logic              busy,
    output logic              sclk,
    output logic              sdo,
    output logic              cs_n
`ifdef COM_RESPONDER_OVR_EN
    ,
    output logic              ovr
`endif
);

    // state   | meaning
    // S_IDLE  | waiting for Write, link idle
    // S_SHIFT | frame on the wire, cs_n low
    // S_DONE  | one-cycle handshake (NewCom/ComEnd high)
    // S_END   | table exhausted, held until reset

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = (CMD_W > 1) ? $clog2(CMD_W) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CMD_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_CMD - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE, S_END} state_t;

    state_t            state, state_n;
    logic [CMD_W-1:0]  shreg, shreg_n;
    logic [DIV_W-1:0]  div, div_n;
    logic [CNT_W-1:0]  bitcnt, bitcnt_n;
    logic [ADDR_W-1:0] addr_n;
    logic              sclk_n, sdo_n, cs_n_n, busy_n, new_com_n, com_end_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            shreg    <= '0;
            div      <= '0;
            bitcnt   <= '0;
            cmd_addr <= '0;
            sclk     <= 1'b0;
            sdo      <= 1'b0;
            cs_n     <= 1'b1;
            busy     <= 1'b0;
            NewCom   <= 1'b0;
            ComEnd   <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            div      <= div_n;
            bitcnt   <= bitcnt_n;
            cmd_addr <= addr_n;
            sclk     <= sclk_n;
            sdo      <= sdo_n;
            cs_n     <= cs_n_n;
            busy     <= busy_n;
            NewCom   <= new_com_n;
            ComEnd   <= com_end_n;
        end
    end

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        div_n     = div;
        bitcnt_n  = bitcnt;
        addr_n    = cmd_addr;
        sclk_n    = sclk;
        new_com_n = 1'b0;
        com_end_n = 1'b0;

        case (state)
            S_IDLE: begin
                sclk_n = 1'b0;
                if (Write) begin
                    shreg_n  = cmd_data;
                    div_n    = '0;
                    bitcnt_n = '0;
                    state_n  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (div == DIV_LAST) begin
                    div_n  = '0;
                    sclk_n = ~sclk;
                    // data advances only on the falling toggle so the DSP sees it stable on rising
                    if (sclk) begin
                        shreg_n  = {shreg[CMD_W-2:0], 1'b0};
                        bitcnt_n = bitcnt + 1'b1;
                        if (bitcnt == CNT_LAST) begin
                            state_n = S_DONE;
                            if (cmd_addr == ADDR_LAST) com_end_n = 1'b1;
                            else                        new_com_n = 1'b1;
                        end
                    end
                end else begin
                    div_n = div + 1'b1;
                end
            end
            S_DONE: begin
                sclk_n = 1'b0;
                if (cmd_addr == ADDR_LAST) begin
                    state_n = S_END;
                end else begin
                    addr_n  = cmd_addr + 1'b1;
                    state_n = S_IDLE;
                end
            end
            S_END: begin
                sclk_n = 1'b0;
            end
            default: begin
                sclk_n  = 1'b0;
                state_n = S_IDLE;
            end
        endcase

        // link outputs are registered from the next state to keep cs_n/sdo glitch-free
        cs_n_n = (state_n != S_SHIFT);
        busy_n = (state_n != S_IDLE);
        sdo_n  = (state_n == S_SHIFT) && shreg_n[CMD_W-1];
    end

`ifdef COM_RESPONDER_OVR_EN
    always_ff @(posedge clk) begin
        if (reset)                          ovr <= 1'b0;
        else if (Write && state != S_IDLE)  ovr <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_com_responder.sv
// Directed bench for com_responder: default instance plus an 8-bit, CLK_DIV=1 corner instance.
module tb_com_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Write = 1'b0;
    logic [15:0] cmd_data;
    logic [2:0]  cmd_addr;
    logic        NewCom, ComEnd, busy, sclk, sdo, cs_n;

    logic        w2 = 1'b0;
    logic [7:0]  d2 = 8'h81;
    logic [2:0]  addr2;
    logic        new_com2, com_end2, busy2, sclk2, sdo2, cs_n2;
`ifdef COM_RESPONDER_OVR_EN
    logic        ovr, ovr2;
`endif

    logic [15:0] rom [8];
    assign cmd_data = rom[cmd_addr];

    com_responder dut (
        .clk(clk), .reset(reset), .Write(Write), .cmd_data(cmd_data), .cmd_addr(cmd_addr),
        .NewCom(NewCom), .ComEnd(ComEnd), .busy(busy), .sclk(sclk), .sdo(sdo), .cs_n(cs_n)
`ifdef COM_RESPONDER_OVR_EN
        , .ovr(ovr)
`endif
    );

    com_responder #(.CMD_W(8), .NUM_CMD(8), .ADDR_W(3), .CLK_DIV(1)) dut2 (
        .clk(clk), .reset(reset), .Write(w2), .cmd_data(d2), .cmd_addr(addr2),
        .NewCom(new_com2), .ComEnd(com_end2), .busy(busy2), .sclk(sclk2), .sdo(sdo2), .cs_n(cs_n2)
`ifdef COM_RESPONDER_OVR_EN
        , .ovr(ovr2)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DSP-side receivers: sample sdo on sclk rising, store complete frames when cs_n rises
    logic [15:0] rx = '0;
    int          rx_cnt = 0;
    logic [15:0] frames [$];
    int          sclk_rises = 0;
    always @(posedge sclk) sclk_rises++;
    always @(posedge sclk or posedge cs_n) begin
        if (cs_n) begin
            if (rx_cnt == 16) frames.push_back(rx);
            rx_cnt = 0;
        end else begin
            rx = {rx[14:0], sdo};
            rx_cnt++;
        end
    end

    logic [7:0] rx2 = '0;
    int         rx2_cnt = 0;
    logic [7:0] frames2 [$];
    int         sclk2_rises = 0;
    always @(posedge sclk2) sclk2_rises++;
    always @(posedge sclk2 or posedge cs_n2) begin
        if (cs_n2) begin
            if (rx2_cnt == 8) frames2.push_back(rx2);
            rx2_cnt = 0;
        end else begin
            rx2 = {rx2[6:0], sdo2};
            rx2_cnt++;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_write(output int n0);
        Write = 1'b1;
        @(negedge clk);
        Write = 1'b0;
        n0 = cyc;
    endtask

    task automatic wait_pulse(input int budget, output bit found, output int at, output bit is_end);
        found = 1'b0; at = 0; is_end = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (NewCom || ComEnd) begin
                found = 1'b1; at = cyc; is_end = ComEnd;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int r0;
        r0 = sclk_rises;
        reset = 1'b1; Write = 1'b1; w2 = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (cs_n !== 1'b1)      begin n_err++; $display("FAIL reset_cs_n: got %b want 1", cs_n); end
        n_cmp++; if (sclk !== 1'b0)      begin n_err++; $display("FAIL reset_sclk: got %b want 0", sclk); end
        n_cmp++; if (sdo !== 1'b0)       begin n_err++; $display("FAIL reset_sdo: got %b want 0", sdo); end
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if ({NewCom, ComEnd} !== 2'b00) begin n_err++; $display("FAIL reset_pulses: got %b want 00", {NewCom, ComEnd}); end
        n_cmp++; if (cmd_addr !== 3'd0)  begin n_err++; $display("FAIL reset_addr: got %0d want 0", cmd_addr); end
        n_cmp++; if (sclk_rises != r0)   begin n_err++; $display("FAIL reset_sclk_activity: got %0d rises want 0", sclk_rises - r0); end
        n_cmp++; if (cs_n2 !== 1'b1 || busy2 !== 1'b0) begin n_err++; $display("FAIL reset_dut2: got cs_n=%b busy=%b want 1 0", cs_n2, busy2); end
`ifdef COM_RESPONDER_OVR_EN
        n_cmp++; if (ovr !== 1'b0)       begin n_err++; $display("FAIL reset_ovr: got %b want 0", ovr); end
`endif
        Write = 1'b0; w2 = 1'b0; reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (cs_n !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL reset_release_idle: got cs_n=%b busy=%b want 1 0", cs_n, busy); end
    endtask

    task automatic test_single();
        int n0, at, f0, r0;
        bit found, is_end;
        do_reset();
        rom[0] = 16'hA5C3;
        f0 = frames.size(); r0 = sclk_rises;
        send_write(n0);
        n_cmp++; if (cs_n !== 1'b0 || sclk !== 1'b0 || sdo !== 1'b1) begin n_err++; $display("FAIL single_start: got cs_n=%b sclk=%b sdo=%b want 0 0 1", cs_n, sclk, sdo); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
        repeat (3) @(negedge clk);
        n_cmp++; if (sclk !== 1'b0) begin n_err++; $display("FAIL single_sclk_e3: got %b want 0", sclk); end
        @(negedge clk);
        n_cmp++; if (sclk !== 1'b1) begin n_err++; $display("FAIL single_sclk_e4: got %b want 1", sclk); end
        wait_pulse(300, found, at, is_end);
        n_cmp++; if (!found)          begin n_err++; $display("FAIL single_timeout: got no pulse want NewCom"); end
        n_cmp++; if (at - n0 != 128)  begin n_err++; $display("FAIL single_latency: got %0d want 128", at - n0); end
        n_cmp++; if (is_end !== 1'b0 || NewCom !== 1'b1) begin n_err++; $display("FAIL single_kind: got NewCom=%b ComEnd=%b want 1 0", NewCom, ComEnd); end
        n_cmp++; if (cs_n !== 1'b1)   begin n_err++; $display("FAIL single_cs_n_done: got %b want 1", cs_n); end
        n_cmp++; if (frames.size() - f0 != 1) begin n_err++; $display("FAIL single_frame_count: got %0d want 1", frames.size() - f0); end
        n_cmp++; if (frames[$] !== 16'hA5C3)  begin n_err++; $display("FAIL single_frame: got %h want a5c3", frames[$]); end
        n_cmp++; if (sclk_rises - r0 != 16)   begin n_err++; $display("FAIL single_sclk_rises: got %0d want 16", sclk_rises - r0); end
        @(negedge clk);
        n_cmp++; if (NewCom !== 1'b0) begin n_err++; $display("FAIL single_pulse_width: got %b want 0", NewCom); end
        n_cmp++; if (cmd_addr !== 3'd1 || busy !== 1'b0) begin n_err++; $display("FAIL single_after: got addr=%0d busy=%b want 1 0", cmd_addr, busy); end
    endtask

    task automatic test_full_sequence();
        int n0, at, f0, f1, r0, nc, ce, lat_bad, quiet_low;
        bit found, is_end;
        do_reset();
        for (int i = 0; i < 8; i++) rom[i] = 16'(16'h1000 + i);
        f0 = frames.size(); nc = 0; ce = 0; lat_bad = 0;
        send_write(n0);
        for (int i = 0; i < 8; i++) begin
            wait_pulse(300, found, at, is_end);
            if (!found) begin
                n_cmp++; n_err++; $display("FAIL seq_timeout: frame %0d got no pulse want pulse", i);
                break;
            end
            if (is_end) ce++; else nc++;
            if (at - n0 != 128) lat_bad++;
            if (!is_end) begin
                @(negedge clk);
                send_write(n0);
            end
        end
        n_cmp++; if (nc != 7)       begin n_err++; $display("FAIL seq_newcom_count: got %0d want 7", nc); end
        n_cmp++; if (ce != 1)       begin n_err++; $display("FAIL seq_comend_count: got %0d want 1", ce); end
        n_cmp++; if (lat_bad != 0)  begin n_err++; $display("FAIL seq_latency: got %0d late frames want 0", lat_bad); end
        n_cmp++; if (frames.size() - f0 != 8) begin n_err++; $display("FAIL seq_frame_count: got %0d want 8", frames.size() - f0); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (frames[f0 + k] !== 16'(16'h1000 + k)) begin n_err++; $display("FAIL seq_frame_%0d: got %h want %h", k, frames[f0 + k], 16'(16'h1000 + k)); end
        end
        @(negedge clk);
        n_cmp++; if (ComEnd !== 1'b0 || busy !== 1'b1 || cmd_addr !== 3'd7) begin n_err++; $display("FAIL seq_end_state: got ComEnd=%b busy=%b addr=%0d want 0 1 7", ComEnd, busy, cmd_addr); end
        r0 = sclk_rises; f1 = frames.size(); quiet_low = 0;
        send_write(n0);
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (cs_n !== 1'b1 || NewCom || ComEnd) quiet_low++;
        end
        n_cmp++; if (sclk_rises != r0 || frames.size() != f1) begin n_err++; $display("FAIL seq_end_ignored: got %0d rises %0d frames want 0 0", sclk_rises - r0, frames.size() - f1); end
        n_cmp++; if (quiet_low != 0 || busy !== 1'b1) begin n_err++; $display("FAIL seq_end_quiet: got %0d active cycles busy=%b want 0 1", quiet_low, busy); end
    endtask

    task automatic test_stray_write();
        int n0, at, f0, extra;
        bit found, is_end;
        do_reset();
        rom[0] = 16'h3C5A; rom[1] = 16'hFFFF;
        f0 = frames.size();
        send_write(n0);
        while (cyc < n0 + 40) @(negedge clk);
`ifdef COM_RESPONDER_OVR_EN
        n_cmp++; if (ovr !== 1'b0) begin n_err++; $display("FAIL stray_ovr_before: got %b want 0", ovr); end
`endif
        Write = 1'b1;
        @(negedge clk);
        Write = 1'b0;
        n_cmp++; if (cs_n !== 1'b0) begin n_err++; $display("FAIL stray_cs_n: got %b want 0", cs_n); end
`ifdef COM_RESPONDER_OVR_EN
        n_cmp++; if (ovr !== 1'b1) begin n_err++; $display("FAIL stray_ovr_set: got %b want 1", ovr); end
`endif
        wait_pulse(300, found, at, is_end);
        n_cmp++; if (!found || is_end)    begin n_err++; $display("FAIL stray_pulse: got found=%b end=%b want 1 0", found, is_end); end
        n_cmp++; if (at - n0 != 128)      begin n_err++; $display("FAIL stray_latency: got %0d want 128", at - n0); end
        n_cmp++; if (frames.size() - f0 != 1 || frames[$] !== 16'h3C5A) begin n_err++; $display("FAIL stray_frame: got %0d frames last %h want 1 3c5a", frames.size() - f0, frames[$]); end
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (NewCom || ComEnd || cs_n !== 1'b1) extra++;
        end
        n_cmp++; if (extra != 0 || cmd_addr !== 3'd1) begin n_err++; $display("FAIL stray_single_newcom: got %0d extra addr=%0d want 0 1", extra, cmd_addr); end
`ifdef COM_RESPONDER_OVR_EN
        n_cmp++; if (ovr !== 1'b1) begin n_err++; $display("FAIL stray_ovr_sticky: got %b want 1", ovr); end
`endif
    endtask

    task automatic test_mid_reset();
        int n0, at, f0;
        bit found, is_end;
        do_reset();
        rom[0] = 16'hC3A5; rom[1] = 16'h0FF0;
        send_write(n0);
        wait_pulse(300, found, at, is_end);
        @(negedge clk);
        n_cmp++; if (cmd_addr !== 3'd1) begin n_err++; $display("FAIL midrst_setup_addr: got %0d want 1", cmd_addr); end
        f0 = frames.size();
        send_write(n0);
        while (cyc < n0 + 70) @(negedge clk);
        n_cmp++; if (cs_n !== 1'b0) begin n_err++; $display("FAIL midrst_active: got cs_n=%b want 0", cs_n); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (cs_n !== 1'b1 || sclk !== 1'b0 || sdo !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL midrst_outputs: got cs_n=%b sclk=%b sdo=%b busy=%b want 1 0 0 0", cs_n, sclk, sdo, busy); end
        n_cmp++; if (cmd_addr !== 3'd0) begin n_err++; $display("FAIL midrst_addr: got %0d want 0", cmd_addr); end
        @(negedge clk);
        send_write(n0);
        wait_pulse(300, found, at, is_end);
        n_cmp++; if (!found || at - n0 != 128) begin n_err++; $display("FAIL midrst_latency: got found=%b lat=%0d want 1 128", found, at - n0); end
        n_cmp++; if (frames.size() - f0 != 1 || frames[$] !== 16'hC3A5) begin n_err++; $display("FAIL midrst_frame: got %0d frames last %h want 1 c3a5", frames.size() - f0, frames[$]); end
    endtask

    task automatic test_div_corner();
        int n0, at, f0, r0;
        bit found;
        do_reset();
        f0 = frames2.size(); r0 = sclk2_rises;
        w2 = 1'b1;
        @(negedge clk);
        w2 = 1'b0;
        n0 = cyc;
        n_cmp++; if (cs_n2 !== 1'b0 || sclk2 !== 1'b0 || sdo2 !== 1'b1 || busy2 !== 1'b1) begin n_err++; $display("FAIL div_start: got cs_n=%b sclk=%b sdo=%b busy=%b want 0 0 1 1", cs_n2, sclk2, sdo2, busy2); end
        @(negedge clk);
        n_cmp++; if (sclk2 !== 1'b1) begin n_err++; $display("FAIL div_sclk_e1: got %b want 1", sclk2); end
        @(negedge clk);
        n_cmp++; if (sclk2 !== 1'b0) begin n_err++; $display("FAIL div_sclk_e2: got %b want 0", sclk2); end
        found = 1'b0; at = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (new_com2 || com_end2) begin found = 1'b1; at = cyc; break; end
        end
        n_cmp++; if (!found || at - n0 != 16 || com_end2 !== 1'b0) begin n_err++; $display("FAIL div_latency: got found=%b lat=%0d end=%b want 1 16 0", found, at - n0, com_end2); end
        n_cmp++; if (frames2.size() - f0 != 1 || frames2[$] !== 8'h81) begin n_err++; $display("FAIL div_frame: got %0d frames last %h want 1 81", frames2.size() - f0, frames2[$]); end
        n_cmp++; if (sclk2_rises - r0 != 8) begin n_err++; $display("FAIL div_sclk_rises: got %0d want 8", sclk2_rises - r0); end
        @(negedge clk);
        n_cmp++; if (new_com2 !== 1'b0 || addr2 !== 3'd1) begin n_err++; $display("FAIL div_after: got NewCom=%b addr=%0d want 0 1", new_com2, addr2); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rom[i] = '0;
        test_reset();
        test_single();
        test_full_sequence();
        test_stray_write();
        test_mid_reset();
        test_div_corner();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation time limit want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
